// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipe_pkg
// Brief    : Shared encodings for the MIPS pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/mips_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : mips_fwd_sel
// Brief    : Priority forwarding select for one EX operand (MEM beats WB).
// Revision : 1.0 - initial release
// ============================================================================
module mips_fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_dest,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_dest,
    input  logic [REG_AW-1:0] i_ex_src,
    output logic [1:0]        o_fwd
);

    always_comb begin
        o_fwd = FWD_REG;
        if (i_mem_reg_write && (i_mem_dest != '0) && (i_mem_dest == i_ex_src)) begin
            o_fwd = FWD_MEM;
        end else if (i_wb_reg_write && (i_wb_dest != '0) && (i_wb_dest == i_ex_src)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule : mips_fwd_sel
`default_nettype wire

// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_hazard_unit
// Brief    : Forwarding, load-use/MUL stall, branch flush and event counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_is_mul,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_mem_read,
    input  logic              ex_is_mul,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              mem_pc_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mul_busy,
    output logic              mul_wb_en,
    output logic [REG_AW-1:0] mul_wb_dest,
    output logic [DATA_W-1:0] stall_cnt,
    output logic [DATA_W-1:0] flush_cnt
);

    localparam int c_NREG  = 2 ** REG_AW;
    localparam int c_CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MUL_LAT - 1);

    mul_state_t        r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_NREG-1:0] r_busy, w_busy_nxt;
    logic [REG_AW-1:0] r_wb_dest, w_wb_dest_nxt;
    logic              w_mul_done;
    logic              w_load_use, w_mul_raw, w_mul_waw, w_mul_struct;
    logic              w_stall, w_stall_eff;
    logic [DATA_W-1:0] r_stall_cnt, r_flush_cnt;

    mips_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_mem_reg_write (mem_reg_write),
        .i_mem_dest      (mem_dest),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_dest       (wb_dest),
        .i_ex_src        (ex_rs),
        .o_fwd           (fwd_a)
    );

    mips_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_mem_reg_write (mem_reg_write),
        .i_mem_dest      (mem_dest),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_dest       (wb_dest),
        .i_ex_src        (ex_rt),
        .o_fwd           (fwd_b)
    );

    assign mul_busy = (r_state == MUL_RUN);

    always_comb begin
        w_load_use   = ex_mem_read && (ex_dest != '0) &&
                       ((id_uses_rs && (ex_dest == id_rs)) || (id_uses_rt && (ex_dest == id_rt)));
        w_mul_raw    = (r_busy[id_rs] && id_uses_rs) || (r_busy[id_rt] && id_uses_rt);
        w_mul_waw    = id_reg_write && r_busy[id_dest];
        w_mul_struct = id_is_mul && mul_busy;
        w_stall      = w_load_use || w_mul_raw || w_mul_waw || w_mul_struct;
        // A taken branch squashes the stalled instruction, so the flush wins.
        w_stall_eff  = w_stall && !mem_pc_src;
    end

    assign pc_write    = !w_stall_eff;
    assign ifid_write  = !w_stall_eff;
    assign idex_bubble = w_stall_eff;
    assign ifid_flush  = mem_pc_src;
    assign idex_flush  = mem_pc_src;
    assign exmem_flush = mem_pc_src;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_wb_dest_nxt = r_wb_dest;
        w_mul_done    = 1'b0;
        case (r_state)
            MUL_IDLE: begin
                // Wrong-path MULs (issued under a taken branch) never start.
                if (ex_is_mul && !mem_pc_src && (ex_dest != '0)) begin
                    w_state_nxt         = MUL_RUN;
                    w_cnt_nxt           = c_CNT_INIT;
                    w_busy_nxt[ex_dest] = 1'b1;
                    w_wb_dest_nxt       = ex_dest;
                end
            end
            MUL_RUN: begin
                if (r_cnt == '0) begin
                    w_mul_done            = 1'b1;
                    w_state_nxt           = MUL_IDLE;
                    w_busy_nxt[r_wb_dest] = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = MUL_IDLE;
        endcase
    end

    assign mul_wb_en   = w_mul_done;
    assign mul_wb_dest = r_wb_dest;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MUL_IDLE;
            r_cnt       <= '0;
            r_busy      <= '0;
            r_wb_dest   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_wb_dest <= w_wb_dest_nxt;
            if (w_stall_eff) begin
                r_stall_cnt <= r_stall_cnt + DATA_W'(1);
            end
            if (mem_pc_src) begin
                r_flush_cnt <= r_flush_cnt + DATA_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : mips_hazard_unit
`default_nettype wire

// File: tb/tb_mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_hazard_unit
// Brief    : Directed vector table plus MUL/reset sequences for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_dest, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        id_uses_rs, id_uses_rt, id_reg_write, id_is_mul;
    logic        ex_mem_read, ex_is_mul, mem_reg_write, wb_reg_write, mem_pc_src;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
    logic        mul_busy, mul_wb_en;
    logic [4:0]  mul_wb_dest;
    logic [31:0] stall_cnt, flush_cnt;

    int n_run  = 0;
    int n_fail = 0;

    mips_hazard_unit #(.DATA_W(32), .REG_AW(5), .MUL_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_is_mul(id_is_mul),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
        .ex_is_mul(ex_is_mul), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .mem_pc_src(mem_pc_src),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .mul_busy(mul_busy), .mul_wb_en(mul_wb_en),
        .mul_wb_dest(mul_wb_dest), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ex_rs, ex_rt, mem_dest, wb_dest, id_rs, id_rt, ex_dest;
        logic       mem_rw, wb_rw, uses_rs, uses_rt, mem_read, pc_src;
        logic [1:0] fa, fb;
        logic       pcw, bub, fl;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic [4:0] ers, input logic [4:0] ert,
        input logic mrw, input logic [4:0] md, input logic wrw, input logic [4:0] wd,
        input logic [4:0] irs, input logic [4:0] irt, input logic urs, input logic urt,
        input logic mrd, input logic [4:0] ed, input logic pcs,
        input logic [1:0] fa, input logic [1:0] fb, input logic pcw, input logic bub,
        input logic fl);
        vec_t v;
        v.ex_rs = ers; v.ex_rt = ert; v.mem_rw = mrw; v.mem_dest = md;
        v.wb_rw = wrw; v.wb_dest = wd; v.id_rs = irs; v.id_rt = irt;
        v.uses_rs = urs; v.uses_rt = urt; v.mem_read = mrd; v.ex_dest = ed;
        v.pc_src = pcs; v.fa = fa; v.fb = fb; v.pcw = pcw; v.bub = bub; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_dest = '0; ex_rs = '0; ex_rt = '0; ex_dest = '0;
        mem_dest = '0; wb_dest = '0; id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0;
        id_is_mul = 0; ex_mem_read = 0; ex_is_mul = 0; mem_reg_write = 0;
        wb_reg_write = 0; mem_pc_src = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;
        //          ers ert mrw md wrw wd irs irt urs urt mrd ed pcs  fa     fb    pcw bub fl
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[1]  = mk(3, 4, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 0, 0);
        vecs[2]  = mk(3, 4, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[4]  = mk(3, 4, 1, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 1, 0, 0);
        vecs[5]  = mk(9, 9, 1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1, 5, 0, 2'b00, 2'b00, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 6, 0, 2'b00, 2'b00, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 5, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 5, 0, 2'b00, 2'b00, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1, 5, 1, 2'b00, 2'b00, 1, 0, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1);

        // Reset state
        reset = 1'b1;
        idle_inputs();
        repeat (2) tick();
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_mul_busy", {31'd0, mul_busy}, 0);
        chk("rst_mul_wb_en", {31'd0, mul_wb_en}, 0);
        chk("rst_mul_wb_dest", {27'd0, mul_wb_dest}, 0);
        chk("rst_pc_write", {31'd0, pc_write}, 1);
        chk("rst_ifid_flush", {31'd0, ifid_flush}, 0);
        reset = 1'b0;

        // Combinational vector table with running counter expectations
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 13; i++) begin
            ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
            mem_reg_write = vecs[i].mem_rw; mem_dest = vecs[i].mem_dest;
            wb_reg_write = vecs[i].wb_rw; wb_dest = vecs[i].wb_dest;
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
            id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
            ex_mem_read = vecs[i].mem_read; ex_dest = vecs[i].ex_dest;
            mem_pc_src = vecs[i].pc_src;
            #2;
            chk($sformatf("v%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].fa});
            chk($sformatf("v%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].fb});
            chk($sformatf("v%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].pcw});
            chk($sformatf("v%0d_ifid_write", i), {31'd0, ifid_write}, {31'd0, vecs[i].pcw});
            chk($sformatf("v%0d_bubble", i), {31'd0, idex_bubble}, {31'd0, vecs[i].bub});
            chk($sformatf("v%0d_flushes", i), {29'd0, ifid_flush, idex_flush, exmem_flush},
                {29'd0, {3{vecs[i].fl}}});
            if (vecs[i].bub) exp_stall++;
            if (vecs[i].fl)  exp_flush++;
            tick();
            chk($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_stall);
            chk($sformatf("v%0d_flush_cnt", i), flush_cnt, exp_flush);
        end

        // MUL to $7 with a dependent reader of $7 in ID
        do_reset();
        ex_is_mul = 1; ex_dest = 7;
        #2;
        chk("mul_c0_busy", {31'd0, mul_busy}, 0);
        tick();
        ex_is_mul = 0; ex_dest = 0; id_rs = 7; id_uses_rs = 1;
        for (int k = 1; k <= 4; k++) begin
            #2;
            chk($sformatf("mul_c%0d_busy", k), {31'd0, mul_busy}, 1);
            chk($sformatf("mul_c%0d_wb_en", k), {31'd0, mul_wb_en}, (k == 4) ? 1 : 0);
            chk($sformatf("mul_c%0d_wb_dest", k), {27'd0, mul_wb_dest}, 7);
            chk($sformatf("mul_c%0d_pc_write", k), {31'd0, pc_write}, 0);
            tick();
        end
        #2;
        chk("mul_done_busy", {31'd0, mul_busy}, 0);
        chk("mul_done_wb_en", {31'd0, mul_wb_en}, 0);
        chk("mul_done_pc_write", {31'd0, pc_write}, 1);
        chk("mul_stall_cnt", stall_cnt, 4);
        tick();

        // Second MUL in ID stalls structurally, then issues
        do_reset();
        ex_is_mul = 1; ex_dest = 7;
        tick();
        ex_is_mul = 0; ex_dest = 0; id_is_mul = 1; id_reg_write = 1; id_dest = 8;
        for (int k = 1; k <= 4; k++) begin
            #2;
            chk($sformatf("mul2_c%0d_stall", k), {31'd0, idex_bubble}, 1);
            tick();
        end
        #2;
        chk("mul2_release", {31'd0, pc_write}, 1);
        id_is_mul = 0; id_reg_write = 0; id_dest = 0; ex_is_mul = 1; ex_dest = 8;
        tick();
        ex_is_mul = 0; ex_dest = 0; id_reg_write = 1; id_dest = 8;
        #2;
        chk("mul2_busy", {31'd0, mul_busy}, 1);
        chk("mul2_wb_dest", {27'd0, mul_wb_dest}, 8);
        chk("mul2_waw_stall", {31'd0, idex_bubble}, 1);
        tick();

        // Wrong-path MUL under a taken branch is not started
        do_reset();
        ex_is_mul = 1; ex_dest = 9; mem_pc_src = 1;
        tick();
        idle_inputs();
        #2;
        chk("wrongpath_busy", {31'd0, mul_busy}, 0);
        chk("wrongpath_flush_cnt", flush_cnt, 1);

        // Reset two cycles into a MUL abandons it
        do_reset();
        ex_is_mul = 1; ex_dest = 7;
        tick();
        ex_is_mul = 0; ex_dest = 0; mem_pc_src = 1;
        tick();
        mem_pc_src = 0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        id_rs = 7; id_uses_rs = 1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("abort_c%0d_busy", k), {31'd0, mul_busy}, 0);
            chk($sformatf("abort_c%0d_wb_en", k), {31'd0, mul_wb_en}, 0);
            chk($sformatf("abort_c%0d_pc_write", k), {31'd0, pc_write}, 1);
            tick();
        end
        chk("abort_stall_cnt", stall_cnt, 0);
        chk("abort_flush_cnt", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_mips_hazard_unit
`default_nettype wire
